// File: rtl/rgb_spi_pkg.sv
// Shared definitions for the RGB SPI command decoder: opcodes, FSM states, speed width.
package rgb_spi_pkg;

    localparam int unsigned SPEED_W = 5;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 5'd31;

    localparam logic [7:0] CMD_SET_ALL = 8'h10;
    localparam logic [7:0] CMD_SET_EN  = 8'h11;
    localparam logic [7:0] CMD_SET_ONE = 8'h12;
    localparam logic [7:0] CMD_READ    = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARGS,
        S_DISCARD,
        S_READ
    } state_t;

    typedef enum logic [1:0] {
        OP_SET_ALL,
        OP_SET_EN,
        OP_SET_ONE
    } op_t;

endpackage

// File: rtl/rgb_spi_cmd_regs_if.sv
// Byte stream from the SPI slave core into the command decoder.
interface rgb_spi_cmd_regs_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_first;

    modport master (output in_data, output in_valid, output in_first);
    modport slave  (input  in_data, input  in_valid, input  in_first);

endinterface

// File: rtl/rgb_spi_sat5.sv
// Combinational 8-bit to 5-bit speed saturator: values above 31 clamp to 31.
module rgb_spi_sat5
    import rgb_spi_pkg::*;
(
    input  logic [7:0]         in_byte,
    output logic [SPEED_W-1:0] speed
);

    always_comb begin
        speed = (|in_byte[7:SPEED_W]) ? SPEED_MAX : in_byte[SPEED_W-1:0];
    end

endmodule

// File: rtl/rgb_spi_cmd_regs.sv
// Command decoder and speed/enable register file for the RGB LED cycle stage.
// Register readback via command 0x20 is built only when RGB_SPI_CMD_READBACK_EN is defined.
module rgb_spi_cmd_regs
    import rgb_spi_pkg::*;
#(
    parameter logic [SPEED_W-1:0] DEF_R_SPEED = 5'd7,
    parameter logic [SPEED_W-1:0] DEF_G_SPEED = 5'd11,
    parameter logic [SPEED_W-1:0] DEF_B_SPEED = 5'd13,
    parameter logic               DEF_ENABLE  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    rgb_spi_cmd_regs_if.slave  bus,
    output logic [SPEED_W-1:0] r_speed,
    output logic [SPEED_W-1:0] g_speed,
    output logic [SPEED_W-1:0] b_speed,
    output logic               enable,
    output logic               upd,
    output logic [7:0]         err_cnt,
    output logic [7:0]         resp_data
);

    state_t             state, state_nxt;
    op_t                op, op_nxt;
    logic [1:0]         idx, idx_nxt;
    logic [SPEED_W-1:0] sh_r, sh_g, sh_r_nxt, sh_g_nxt;
    logic [1:0]         sh_ch, sh_ch_nxt;
    logic [SPEED_W-1:0] r_nxt, g_nxt, b_nxt;
    logic               en_nxt, upd_nxt, err_inc;
    logic [SPEED_W-1:0] arg_sat;

    rgb_spi_sat5 u_sat (
        .in_byte (bus.in_data),
        .speed   (arg_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op      <= OP_SET_ALL;
            idx     <= '0;
            sh_r    <= '0;
            sh_g    <= '0;
            sh_ch   <= '0;
            r_speed <= DEF_R_SPEED;
            g_speed <= DEF_G_SPEED;
            b_speed <= DEF_B_SPEED;
            enable  <= DEF_ENABLE;
            upd     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            op      <= op_nxt;
            idx     <= idx_nxt;
            sh_r    <= sh_r_nxt;
            sh_g    <= sh_g_nxt;
            sh_ch   <= sh_ch_nxt;
            r_speed <= r_nxt;
            g_speed <= g_nxt;
            b_speed <= b_nxt;
            enable  <= en_nxt;
            upd     <= upd_nxt;
            if (err_inc && err_cnt != '1) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // A first-flagged byte restarts decoding from any state; partial shadows are simply dropped.
    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        idx_nxt   = idx;
        sh_r_nxt  = sh_r;
        sh_g_nxt  = sh_g;
        sh_ch_nxt = sh_ch;
        r_nxt     = r_speed;
        g_nxt     = g_speed;
        b_nxt     = b_speed;
        en_nxt    = enable;
        upd_nxt   = 1'b0;
        err_inc   = 1'b0;
        if (bus.in_valid && bus.in_first) begin
            idx_nxt = '0;
            case (bus.in_data)
                CMD_SET_ALL: begin state_nxt = S_ARGS; op_nxt = OP_SET_ALL; end
                CMD_SET_EN:  begin state_nxt = S_ARGS; op_nxt = OP_SET_EN;  end
                CMD_SET_ONE: begin state_nxt = S_ARGS; op_nxt = OP_SET_ONE; end
`ifdef RGB_SPI_CMD_READBACK_EN
                CMD_READ:    state_nxt = S_READ;
`endif
                default: begin
                    state_nxt = S_DISCARD;
                    err_inc   = 1'b1;
                end
            endcase
        end else if (bus.in_valid && state == S_ARGS) begin
            case (op)
                OP_SET_ALL: begin
                    case (idx)
                        2'd0: begin sh_r_nxt = arg_sat; idx_nxt = 2'd1; end
                        2'd1: begin sh_g_nxt = arg_sat; idx_nxt = 2'd2; end
                        default: begin
                            r_nxt     = sh_r;
                            g_nxt     = sh_g;
                            b_nxt     = arg_sat;
                            upd_nxt   = 1'b1;
                            state_nxt = S_DISCARD;
                        end
                    endcase
                end
                OP_SET_EN: begin
                    en_nxt    = bus.in_data[0];
                    upd_nxt   = 1'b1;
                    state_nxt = S_DISCARD;
                end
                default: begin
                    if (idx == 2'd0) begin
                        if (bus.in_data > 8'd2) begin
                            err_inc   = 1'b1;
                            state_nxt = S_DISCARD;
                        end else begin
                            sh_ch_nxt = bus.in_data[1:0];
                            idx_nxt   = 2'd1;
                        end
                    end else begin
                        case (sh_ch)
                            2'd0:    r_nxt = arg_sat;
                            2'd1:    g_nxt = arg_sat;
                            default: b_nxt = arg_sat;
                        endcase
                        upd_nxt   = 1'b1;
                        state_nxt = S_DISCARD;
                    end
                end
            endcase
        end
    end

`ifdef RGB_SPI_CMD_READBACK_EN
    logic [2:0] rd_idx, rd_idx_nxt;
    logic [7:0] resp_nxt;

    always_comb begin
        resp_nxt   = resp_data;
        rd_idx_nxt = rd_idx;
        if (bus.in_valid && bus.in_first) begin
            resp_nxt   = '0;
            rd_idx_nxt = '0;
            if (bus.in_data == CMD_READ) begin
                resp_nxt   = {enable, 2'b00, r_speed};
                rd_idx_nxt = 3'd1;
            end
        end else if (bus.in_valid && state == S_READ) begin
            case (rd_idx)
                3'd1:    resp_nxt = {3'b000, g_speed};
                3'd2:    resp_nxt = {3'b000, b_speed};
                3'd3:    resp_nxt = err_cnt;
                default: resp_nxt = '0;
            endcase
            if (rd_idx != 3'd4) begin
                rd_idx_nxt = rd_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx    <= '0;
            resp_data <= '0;
        end else begin
            rd_idx    <= rd_idx_nxt;
            resp_data <= resp_nxt;
        end
    end
`else
    assign resp_data = '0;
`endif

endmodule

// File: tb/tb_rgb_spi_cmd_regs.sv
// Self-checking bench for rgb_spi_cmd_regs against a transaction-level reference model.
module tb_rgb_spi_cmd_regs;

    logic       clk;
    logic       rst_n;
    logic [4:0] r_speed, g_speed, b_speed;
    logic       enable, upd;
    logic [7:0] err_cnt, resp_data;

    int checks   = 0;
    int failures = 0;

    rgb_spi_cmd_regs_if bus();

    rgb_spi_cmd_regs #(
        .DEF_R_SPEED (5'd7),
        .DEF_G_SPEED (5'd11),
        .DEF_B_SPEED (5'd13),
        .DEF_ENABLE  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .r_speed   (r_speed),
        .g_speed   (g_speed),
        .b_speed   (b_speed),
        .enable    (enable),
        .upd       (upd),
        .err_cnt   (err_cnt),
        .resp_data (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the bytes of the current transaction and the register image.
    logic [7:0] q[$];
    logic [4:0] m_r, m_g, m_b;
    logic       m_en, m_upd;
    logic [7:0] m_err, m_resp;

    function automatic logic [4:0] sat(input logic [7:0] v);
        return (v > 8'd31) ? 5'd31 : v[4:0];
    endfunction

    function automatic logic [32:0] obs();
        return {r_speed, g_speed, b_speed, enable, err_cnt, resp_data, upd};
    endfunction

    function automatic logic [32:0] expv();
        return {m_r, m_g, m_b, m_en, m_err, m_resp, m_upd};
    endfunction

    task automatic model_reset();
        q.delete();
        m_r = 5'd7; m_g = 5'd11; m_b = 5'd13; m_en = 1'b1;
        m_upd = 1'b0; m_err = 8'd0; m_resp = 8'd0;
    endtask

    task automatic bump_err();
        if (m_err != 8'd255) m_err = m_err + 8'd1;
    endtask

    task automatic model_byte(input logic [7:0] d, input logic first);
        int n;
        m_upd = 1'b0;
        if (first) begin
            q.delete();
            m_resp = 8'd0;
        end
        if (first || q.size() != 0) begin
            q.push_back(d);
            n = q.size();
            case (q[0])
                8'h10: if (n == 4) begin
                    m_r = sat(q[1]); m_g = sat(q[2]); m_b = sat(q[3]); m_upd = 1'b1;
                end
                8'h11: if (n == 2) begin
                    m_en = q[1][0]; m_upd = 1'b1;
                end
                8'h12: begin
                    if (n == 2 && q[1] > 8'd2) bump_err();
                    else if (n == 3 && q[1] <= 8'd2) begin
                        if (q[1] == 8'd0) m_r = sat(q[2]);
                        else if (q[1] == 8'd1) m_g = sat(q[2]);
                        else m_b = sat(q[2]);
                        m_upd = 1'b1;
                    end
                end
`ifdef RGB_SPI_CMD_READBACK_EN
                8'h20: begin
                    if (n == 1) m_resp = {m_en, 2'b00, m_r};
                    else if (n == 2) m_resp = {3'b000, m_g};
                    else if (n == 3) m_resp = {3'b000, m_b};
                    else if (n == 4) m_resp = m_err;
                    else m_resp = 8'd0;
                end
`endif
                default: if (n == 1) bump_err();
            endcase
        end
    endtask

    task automatic send(input logic [7:0] d, input logic first);
        @(negedge clk);
        bus.in_data  = d;
        bus.in_first = first;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        model_byte(d, first);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        m_upd = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] junk[3] = '{8'h10, 8'h03, 8'h11};
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_first = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_hold obs=%h exp=%h", obs(), expv());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_release obs=%h exp=%h", obs(), expv());
        end
        // Non-first bytes before any command must be dropped.
        for (int i = 0; i < 3; i++) begin
            send(junk[i], 1'b0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL idle_drop byte%0d obs=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_set_all();
        logic [7:0] t[4] = '{8'h10, 8'h03, 8'h05, 8'h1F};
        for (int i = 0; i < 4; i++) begin
            send(t[i], i == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL set_all byte%0d obs=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if ({r_speed, g_speed, b_speed, upd} !== {5'd3, 5'd5, 5'd31, 1'b1}) begin
            failures++;
            $display("FAIL set_all_commit obs=%h exp=%h", {r_speed, g_speed, b_speed, upd},
                     {5'd3, 5'd5, 5'd31, 1'b1});
        end
        idle();
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL set_all_upd_drop obs=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_saturate();
        logic [7:0] t[4] = '{8'h10, 8'h40, 8'h02, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            send(t[i], i == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL saturate byte%0d obs=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if ({r_speed, g_speed, b_speed} !== {5'd31, 5'd2, 5'd31}) begin
            failures++;
            $display("FAIL saturate_vals obs=%h exp=%h", {r_speed, g_speed, b_speed},
                     {5'd31, 5'd2, 5'd31});
        end
    endtask

    task automatic test_abandon();
        logic [7:0] t[5] = '{8'h10, 8'h04, 8'h04, 8'h11, 8'h00};
        logic       f[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send(t[i], f[i]);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL abandon byte%0d obs=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if ({r_speed, g_speed, b_speed, enable, err_cnt} !== {5'd31, 5'd2, 5'd31, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL abandon_final obs=%h exp=%h", {r_speed, g_speed, b_speed, enable, err_cnt},
                     {5'd31, 5'd2, 5'd31, 1'b0, 8'd0});
        end
    endtask

    task automatic test_errors();
        logic [7:0] t[5] = '{8'h55, 8'h01, 8'h12, 8'h03, 8'h09};
        logic       f[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send(t[i], f[i]);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL errors byte%0d obs=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if (err_cnt !== 8'd2) begin
            failures++;
            $display("FAIL errors_count obs=%0d exp=2", err_cnt);
        end
    endtask

    task automatic test_readback();
        logic [7:0] t[11] = '{8'h10, 8'h03, 8'h05, 8'h1F, 8'h11, 8'h01,
                              8'h20, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        logic [7:0] rsp[5];
`ifdef RGB_SPI_CMD_READBACK_EN
        rsp = '{8'h83, 8'h05, 8'h1F, 8'h02, 8'h00};
`else
        rsp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        for (int i = 0; i < 11; i++) begin
            send(t[i], i == 0 || i == 4 || i == 6);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL readback byte%0d obs=%h exp=%h", i, obs(), expv());
            end
            if (i >= 6) begin
                checks++;
                if (resp_data !== rsp[i-6]) begin
                    failures++;
                    $display("FAIL readback_resp idx%0d obs=%h exp=%h", i - 6, resp_data, rsp[i-6]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ops[5] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h00};
        logic [7:0] cmd, arg;
        int nargs;
        for (int t = 0; t < 200; t++) begin
            cmd = ops[$urandom_range(0, 4)];
            if (cmd == 8'h00) cmd = 8'($urandom_range(0, 255));
            nargs = $urandom_range(0, 5);
            send(cmd, 1'b1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random t%0d cmd obs=%h exp=%h", t, obs(), expv());
            end
            for (int a = 0; a < nargs; a++) begin
                if (cmd == 8'h12 && a == 0) arg = 8'($urandom_range(0, 3));
                else arg = 8'($urandom_range(0, 255));
                send(arg, 1'b0);
                checks++;
                if (obs() !== expv()) begin
                    failures++;
                    $display("FAIL random t%0d arg%0d obs=%h exp=%h", t, a, obs(), expv());
                end
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    checks++;
                    if (obs() !== expv()) begin
                        failures++;
                        $display("FAIL random_gap t%0d arg%0d obs=%h exp=%h", t, a, obs(), expv());
                    end
                end
            end
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 300; i++) begin
            send(8'h55, 1'b1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL err_sat step%0d obs=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL err_sat_final obs=%0d exp=255", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_set_all();
        test_saturate();
        test_abandon();
        test_errors();
        test_readback();
        test_random();
        test_err_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_spi_cmd_regs.md
Name: rgb_spi_cmd_regs

Overview:
- Command decoder and register file directly upstream of the RGB LED cycle stage.
- Consumes the byte stream from the SPI slave core (one byte per in_valid strobe, in_first marks the first byte after CS assert).
- Parses short commands and drives the registered r_speed/g_speed/b_speed/enable inputs of the cycle stage, with atomic multi-byte updates and an error counter.

Parameters:
- DEF_R_SPEED, 5'd7, r_speed reset value
- DEF_G_SPEED, 5'd11, g_speed reset value
- DEF_B_SPEED, 5'd13, b_speed reset value
- DEF_ENABLE, 1'b1, enable reset value

Ports:
- clk  in  1  system clock; all logic single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- in_data  in  8  received SPI byte
- in_valid  in  1  one-cycle strobe, in_data valid
- in_first  in  1  qualifies in_valid: byte is first of transaction
- r_speed  out  5  red speed to cycle stage
- g_speed  out  5  green speed to cycle stage
- b_speed  out  5  blue speed to cycle stage
- enable  out  1  cycle enable
- upd  out  1  one-cycle pulse, cycle after any register commit
- err_cnt  out  8  saturating count of malformed/unknown commands
- resp_data  out  8  readback byte for SPI slave TX (0 when feature disabled)

Behaviour:
- Reset (rst_n low, async):
  - speeds = DEF_*, enable = DEF_ENABLE
  - upd = 0, err_cnt = 0, resp_data = 0
  - FSM = S_IDLE; shadow registers cleared
- FSM states:
  - S_IDLE: wait for command byte.
  - S_ARGS: collecting arguments; arg index 0..2.
  - S_DISCARD: ignore bytes until next in_first.
  - S_READ: feature only.
- Any in_valid with in_first=1, in any state, is a command byte. It abandons an in-progress command with no register change and no error count. in_valid with in_first=0 while in S_IDLE is dropped.
- Commands (first byte):
  - 0x10 SET_ALL: 3 args R, G, B. Committed together on 3rd arg.
  - 0x11 SET_EN: 1 arg; enable = arg[0].
  - 0x12 SET_ONE: 2 args, channel (0=R, 1=G, 2=B), speed. Channel >2 → error, S_DISCARD.
  - Any other command byte → error, S_DISCARD.
- Speed args > 31 saturate to 31 (not truncated).
- Bytes after a completed command, within the same transaction → S_DISCARD, no error.
- Commit timing: final arg byte on cycle N → outputs and upd=1 valid at N+1. upd high for exactly one cycle. Outputs change only at commit.
- err_cnt: +1 per error event, saturates at 255 and never wraps.
- Unchanged values still pulse upd on commit.

Optional Feature:
- Macro RGB_SPI_CMD_READBACK_EN.
- Defined: command 0x20 READ enters S_READ.
  - resp_data loaded at N+1 with {enable,2'b00,r_speed}.
  - Each following non-first in_valid advances the index: {3'b0,g_speed}, {3'b0,b_speed}, err_cnt, then 0x00 for all further bytes.
  - resp_data returns to 0 on a new in_first.
- Undefined: 0x20 is an unknown command (error); resp_data tied 0.

Decomposition:
- Shared package rgb_spi_pkg: command opcodes (CMD_SET_ALL=8'h10, CMD_SET_EN=8'h11, CMD_SET_ONE=8'h12, CMD_READ=8'h20), FSM state encoding, SPEED_W=5, SPEED_MAX=31.
- One natural sub-module: rgb_spi_sat5, a combinational 8→5 saturator instanced per argument path.
- FSM and register file stay in the top.

Test Plan:
- Reset release: speeds = 7/11/13, enable=1, err_cnt=0, upd=0.
- First 0x10, then 0x03, 0x05, 0x1F: after the 3rd byte, the next cycle shows r=3, g=5, b=31 with upd=1 for 1 cycle. No output change after 1st or 2nd arg.
- First 0x10, then 0x40, 0x02, 0xFF: r=31, g=2, b=31 (saturation).
- First 0x10, then 0x04, 0x04; then new first 0x11, 0x00: speeds unchanged, enable=0, err_cnt=0.
- First 0x55, then 0x01; first 0x12, 0x03, 0x09: err_cnt=2, no upd. Repeat 300 errors → err_cnt=255.
- With RGB_SPI_CMD_READBACK_EN: after SET_ALL 3/5/31 with enable=1, first 0x20 then 4 bytes. resp_data sequence 0x83, 0x05, 0x1F, err_cnt, then 0x00. Without the macro, err_cnt increments and resp_data stays 0.
